// File: rtl/divider_taint_track.sv
// Constant-time restoring unsigned divider with conservative bitwise taint tracking.
// Every division runs exactly WIDTH iteration cycles, divide-by-zero included.
module divider_taint_track #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             done,
  output logic             done_t
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_t;
  logic [WIDTH:0]   r_r;
  logic [WIDTH:0]   r_r_t;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_d_t;
  logic             r_ctrl_t;
  logic             r_done;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_diff;
  logic             w_sel;
  logic [WIDTH:0]   w_rs_t;
  logic             w_sel_t;
  logic [WIDTH:0]   w_r_t_next;

  // Both the subtract and the restore path are always evaluated.
  assign w_rs    = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff  = w_rs - {1'b0, r_d};
  assign w_sel   = ~w_diff[WIDTH];

  // The borrow chain mixes every bit, so any tainted input taints the whole difference.
  assign w_rs_t     = {r_r_t[WIDTH-1:0], r_q_t[WIDTH-1]};
  assign w_sel_t    = (|w_rs_t) | (|r_d_t);
  assign w_r_t_next = (w_sel ? {(WIDTH+1){w_sel_t}} : w_rs_t) | {(WIDTH+1){w_sel_t}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_q      <= '0;
      r_q_t    <= '0;
      r_r      <= '0;
      r_r_t    <= '0;
      r_d      <= '0;
      r_d_t    <= '0;
      r_ctrl_t <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_ITER;
            r_cnt    <= '0;
            r_q      <= dividend;
            r_q_t    <= dividend_t;
            r_r      <= '0;
            r_r_t    <= '0;
            r_d      <= divisor;
            r_d_t    <= divisor_t;
            r_ctrl_t <= start_t;
            r_done   <= 1'b0;
          end
        end
        S_ITER: begin
          r_r   <= w_sel ? w_diff : w_rs;
          r_q   <= {r_q[WIDTH-2:0], w_sel};
          r_r_t <= w_r_t_next;
          r_q_t <= {r_q_t[WIDTH-2:0], w_sel_t};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = r_q;
  assign quotient_t  = r_q_t;
  assign remainder   = r_r[WIDTH-1:0];
  assign remainder_t = r_r_t[WIDTH-1:0];
  assign done        = r_done;
  assign done_t      = r_ctrl_t;

endmodule

// File: tb/tb_divider_taint_track.sv
// Directed-vector bench for divider_taint_track at WIDTH=8: latency, results,
// taint propagation, busy-start rejection and asynchronous mid-division reset.
module tb_divider_taint_track;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         start_t;
  logic [W-1:0] dividend;
  logic [W-1:0] dividend_t;
  logic [W-1:0] divisor;
  logic [W-1:0] divisor_t;
  logic [W-1:0] quotient;
  logic [W-1:0] quotient_t;
  logic [W-1:0] remainder;
  logic [W-1:0] remainder_t;
  logic         done;
  logic         done_t;

  int n_checks = 0;
  int n_pass   = 0;

  divider_taint_track #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_t     (start_t),
    .dividend    (dividend),
    .dividend_t  (dividend_t),
    .divisor     (divisor),
    .divisor_t   (divisor_t),
    .quotient    (quotient),
    .quotient_t  (quotient_t),
    .remainder   (remainder),
    .remainder_t (remainder_t),
    .done        (done),
    .done_t      (done_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-12s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-12s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned away from a clock edge. busy_at>0 injects a tainted
  // start (different operands) sampled at the edge busy_at after the load edge.
  task automatic do_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic [W-1:0] dvd_t, input logic [W-1:0] dvs_t,
                        input logic st_t, input int busy_at);
    dividend   = dvd;
    divisor    = dvs;
    dividend_t = dvd_t;
    divisor_t  = dvs_t;
    start_t    = st_t;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_t = 1'b0;
    check("load_done", {15'd0, done}, 16'd0);
    check("load_done_t", {15'd0, done_t}, {15'd0, st_t});
    if (busy_at == 1) begin
      start = 1'b1; start_t = 1'b1; dividend = 8'd200; divisor = 8'd3;
    end
    for (int e = 1; e <= W; e++) begin
      @(posedge clk);
      #1;
      if (busy_at > 0 && e == busy_at - 1) begin
        start = 1'b1; start_t = 1'b1; dividend = 8'd200; divisor = 8'd3;
      end
      if (busy_at > 0 && e == busy_at) begin
        start = 1'b0; start_t = 1'b0;
      end
      if (e == W - 1) check("lat_pre", {15'd0, done}, 16'd0);
      if (e == W)     check("lat_done", {15'd0, done}, 16'd1);
    end
  endtask

  task automatic check_result(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic [W-1:0] qt, input logic [W-1:0] rt,
                              input logic dt);
    check("quotient", {8'd0, quotient}, {8'd0, q});
    check("remainder", {8'd0, remainder}, {8'd0, r});
    check("quotient_t", {8'd0, quotient_t}, {8'd0, qt});
    check("remainder_t", {8'd0, remainder_t}, {8'd0, rt});
    check("done_t", {15'd0, done_t}, {15'd0, dt});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_t = 1'b0;
    dividend = '0; dividend_t = '0; divisor = '0; divisor_t = '0;
    #12;
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_done_t", {15'd0, done_t}, 16'd0);
    check("rst_q", {8'd0, quotient}, 16'd0);
    check("rst_r", {8'd0, remainder}, 16'd0);
    rst = 1'b1;

    // Basic 100/7.
    do_div(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 0);
    check_result(8'd14, 8'd2, 8'h00, 8'h00, 1'b0);

    // Divide-by-zero, back-to-back from DONE.
    do_div(8'd200, 8'd0, 8'h00, 8'h00, 1'b0, 0);
    check_result(8'hFF, 8'd200, 8'h00, 8'h00, 1'b0);

    // Divisor taint saturates both results.
    do_div(8'h55, 8'h03, 8'h00, 8'h80, 1'b0, 0);
    check_result(8'h1C, 8'd1, 8'hFF, 8'hFF, 1'b0);

    // Control taint set, then cleared by an untainted start.
    do_div(8'd9, 8'd3, 8'h00, 8'h00, 1'b1, 0);
    check_result(8'd3, 8'd0, 8'h00, 8'h00, 1'b1);
    do_div(8'd10, 8'd5, 8'h00, 8'h00, 1'b0, 0);
    check_result(8'd2, 8'd0, 8'h00, 8'h00, 1'b0);

    // Tainted start three edges into a busy division is ignored.
    do_div(8'd50, 8'd5, 8'h00, 8'h00, 1'b0, 3);
    check_result(8'd10, 8'd0, 8'h00, 8'h00, 1'b0);

    // Asynchronous reset during cycle 4 of a division.
    dividend = 8'd77; divisor = 8'd4; dividend_t = 8'h0F; divisor_t = 8'h00;
    start_t = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start_t = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mrst_done", {15'd0, done}, 16'd0);
    check("mrst_done_t", {15'd0, done_t}, 16'd0);
    check("mrst_q", {8'd0, quotient}, 16'd0);
    check("mrst_qt", {8'd0, quotient_t}, 16'd0);
    check("mrst_r", {8'd0, remainder}, 16'd0);
    check("mrst_rt", {8'd0, remainder_t}, 16'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_done", {15'd0, done}, 16'd0);
    check("idle_q", {8'd0, quotient}, 16'd0);
    dividend_t = 8'h00;
    do_div(8'd255, 8'd16, 8'h00, 8'h00, 1'b0, 0);
    check_result(8'd15, 8'd15, 8'h00, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
